// File: rtl/gshare_btb.sv
// gshare_btb: gshare direction predictor with a set-associative branch target buffer.
//
// Purpose:
//   IF side: a combinational lookup of pc_if in the BTB and the PHT gives the predicted
//   direction and next PC. The global history register (GHR) shifts speculatively on a
//   BTB hit.
//   EX side: resolved branches train the PHT and the BTB. A misprediction restores the
//   GHR from the history the branch carried down the pipe. EX updates are never
//   bypassed to a same-cycle IF lookup.
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   if_valid, pc_if             fetch slot valid, fetch PC
//   npc_pred, pred_taken        predicted next PC and direction
//   pred_ghr                    pre-shift GHR used for this prediction
//   ex_valid, ex_is_br          EX slot valid, EX instruction is a conditional branch
//   ex_taken, ex_pc, ex_target  actual outcome, EX PC, resolved branch target
//   ex_pred_taken, ex_ghr       prediction and history carried from IF
//   ex_mispredict               EX branch resolved against its prediction
//   cnt_correct, cnt_wrong      saturating prediction statistics
module gshare_btb #(
    parameter int unsigned SETS_LOG2 = 2,
    parameter int unsigned WAYS      = 2,
    parameter int unsigned GHR_LEN   = 4,
    parameter int unsigned PHT_LOG2  = 6,
    parameter int unsigned CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid,
    input  logic [31:0]        pc_if,
    output logic [31:0]        npc_pred,
    output logic               pred_taken,
    output logic [GHR_LEN-1:0] pred_ghr,
    input  logic               ex_valid,
    input  logic               ex_is_br,
    input  logic               ex_taken,
    input  logic [31:0]        ex_pc,
    input  logic [31:0]        ex_target,
    input  logic               ex_pred_taken,
    input  logic [GHR_LEN-1:0] ex_ghr,
    output logic               ex_mispredict,
    output logic [CNT_W-1:0]   cnt_correct,
    output logic [CNT_W-1:0]   cnt_wrong
);

    localparam int unsigned SETS  = 1 << SETS_LOG2;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned TAG_W = 30 - SETS_LOG2;
    localparam int unsigned PHT_N = 1 << PHT_LOG2;

    // BTB storage
    logic [WAYS-1:0]  r_valid  [SETS];
    logic [TAG_W-1:0] r_tag    [SETS][WAYS];
    logic [31:0]      r_target [SETS][WAYS];
    logic [WAY_W-1:0] r_age    [SETS][WAYS];

    // Predictor state
    logic [1:0]         r_pht [PHT_N];
    logic [GHR_LEN-1:0] r_ghr;
    logic [CNT_W-1:0]   r_cnt_correct;
    logic [CNT_W-1:0]   r_cnt_wrong;

    // IF lookup
    logic [SETS_LOG2-1:0] w_if_set;
    logic [TAG_W-1:0]     w_if_tag;
    logic [PHT_LOG2-1:0]  w_if_idx;
    logic                 w_if_hit;
    logic [31:0]          w_if_target;
    logic                 w_if_taken;

    assign w_if_set = pc_if[SETS_LOG2+1:2];
    assign w_if_tag = pc_if[31:SETS_LOG2+2];
    assign w_if_idx = pc_if[PHT_LOG2+1:2] ^ PHT_LOG2'(r_ghr);

    always_comb begin
        w_if_hit    = 1'b0;
        w_if_target = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (r_valid[w_if_set][i] && (r_tag[w_if_set][i] == w_if_tag)) begin
                w_if_hit    = 1'b1;
                w_if_target = r_target[w_if_set][i];
            end
        end
    end

    // Gating with rst keeps the outputs at their reset values for the whole reset window.
    assign w_if_taken = w_if_hit & r_pht[w_if_idx][1] & ~rst;
    assign pred_taken = w_if_taken;
    assign npc_pred   = w_if_taken ? w_if_target : pc_if + 32'd4;
    assign pred_ghr   = rst ? '0 : r_ghr;

    // EX lookup and replacement choice
    logic [SETS_LOG2-1:0] w_ex_set;
    logic [TAG_W-1:0]     w_ex_tag;
    logic [PHT_LOG2-1:0]  w_ex_idx;
    logic                 w_ex_hit;
    logic [WAY_W-1:0]     w_ex_hit_way;
    logic                 w_found_inv;
    logic [WAY_W-1:0]     w_inv_way;
    logic [WAY_W-1:0]     w_old_way;
    logic [WAY_W-1:0]     w_max_age;
    logic [WAY_W-1:0]     w_touch_way;
    logic [WAY_W-1:0]     w_touch_age;
    logic                 w_ex_br;
    logic                 w_ex_touch;
    logic                 w_ex_stale;

    assign w_ex_set = ex_pc[SETS_LOG2+1:2];
    assign w_ex_tag = ex_pc[31:SETS_LOG2+2];
    assign w_ex_idx = ex_pc[PHT_LOG2+1:2] ^ PHT_LOG2'(ex_ghr);

    always_comb begin
        w_ex_hit     = 1'b0;
        w_ex_hit_way = '0;
        w_found_inv  = 1'b0;
        w_inv_way    = '0;
        w_old_way    = '0;
        w_max_age    = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (r_valid[w_ex_set][i] && (r_tag[w_ex_set][i] == w_ex_tag)) begin
                w_ex_hit     = 1'b1;
                w_ex_hit_way = WAY_W'(i);
            end
            if (!w_found_inv && !r_valid[w_ex_set][i]) begin
                w_found_inv = 1'b1;
                w_inv_way   = WAY_W'(i);
            end
            if (r_age[w_ex_set][i] > w_max_age) begin
                w_max_age = r_age[w_ex_set][i];
                w_old_way = WAY_W'(i);
            end
        end
    end

    assign w_ex_br       = ex_valid & ex_is_br;
    assign ex_mispredict = w_ex_br & (ex_taken != ex_pred_taken);
    // A not-taken miss leaves the BTB (including LRU) untouched.
    assign w_ex_touch    = w_ex_br & (w_ex_hit | ex_taken);
    assign w_touch_way   = w_ex_hit ? w_ex_hit_way : (w_found_inv ? w_inv_way : w_old_way);
    assign w_touch_age   = r_age[w_ex_set][w_touch_way];
    // A non-branch that hits means the entry is stale (e.g. code was overwritten).
    assign w_ex_stale    = ex_valid & ~ex_is_br & w_ex_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_tag[s][w]    <= '0;
                    r_target[s][w] <= '0;
                    r_age[s][w]    <= WAY_W'(w);
                end
            end
            for (int p = 0; p < PHT_N; p++) begin
                r_pht[p] <= 2'b01;
            end
            r_ghr         <= '0;
            r_cnt_correct <= '0;
            r_cnt_wrong   <= '0;
        end else begin
            if (w_ex_touch) begin
                for (int i = 0; i < WAYS; i++) begin
                    if (WAY_W'(i) == w_touch_way) begin
                        r_age[w_ex_set][i] <= '0;
                    end else if (r_age[w_ex_set][i] < w_touch_age) begin
                        r_age[w_ex_set][i] <= r_age[w_ex_set][i] + WAY_W'(1);
                    end
                end
                r_target[w_ex_set][w_touch_way] <= ex_target;
                if (!w_ex_hit) begin
                    r_valid[w_ex_set][w_touch_way] <= 1'b1;
                    r_tag[w_ex_set][w_touch_way]   <= w_ex_tag;
                end
            end
            if (w_ex_stale) begin
                r_valid[w_ex_set][w_ex_hit_way] <= 1'b0;
            end

            if (w_ex_br) begin
                if (ex_taken && (r_pht[w_ex_idx] != 2'b11)) begin
                    r_pht[w_ex_idx] <= r_pht[w_ex_idx] + 2'b01;
                end else if (!ex_taken && (r_pht[w_ex_idx] != 2'b00)) begin
                    r_pht[w_ex_idx] <= r_pht[w_ex_idx] - 2'b01;
                end
                if (ex_mispredict) begin
                    if (r_cnt_wrong != '1) r_cnt_wrong <= r_cnt_wrong + CNT_W'(1);
                end else begin
                    if (r_cnt_correct != '1) r_cnt_correct <= r_cnt_correct + CNT_W'(1);
                end
            end

            // Recovery from EX wins over the speculative IF shift.
            if (ex_mispredict) begin
                r_ghr <= {ex_ghr[GHR_LEN-2:0], ex_taken};
            end else if (if_valid && w_if_hit) begin
                r_ghr <= {r_ghr[GHR_LEN-2:0], w_if_taken};
            end
        end
    end

    assign cnt_correct = r_cnt_correct;
    assign cnt_wrong   = r_cnt_wrong;

endmodule

// File: tb/tb_gshare_btb.sv
// tb_gshare_btb: directed self-checking bench for gshare_btb at default parameters.
module tb_gshare_btb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] pc_if;
    logic [31:0] npc_pred;
    logic        pred_taken;
    logic [3:0]  pred_ghr;
    logic        ex_valid;
    logic        ex_is_br;
    logic        ex_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [3:0]  ex_ghr;
    logic        ex_mispredict;
    logic [31:0] cnt_correct;
    logic [31:0] cnt_wrong;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gshare_btb dut (
        .clk           (clk),
        .rst           (rst),
        .if_valid      (if_valid),
        .pc_if         (pc_if),
        .npc_pred      (npc_pred),
        .pred_taken    (pred_taken),
        .pred_ghr      (pred_ghr),
        .ex_valid      (ex_valid),
        .ex_is_br      (ex_is_br),
        .ex_taken      (ex_taken),
        .ex_pc         (ex_pc),
        .ex_target     (ex_target),
        .ex_pred_taken (ex_pred_taken),
        .ex_ghr        (ex_ghr),
        .ex_mispredict (ex_mispredict),
        .cnt_correct   (cnt_correct),
        .cnt_wrong     (cnt_wrong)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Combinational lookup of pc with if_valid low; checks direction and next PC.
    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_tk,
                          input logic [31:0] exp_npc);
        if_valid = 1'b0;
        pc_if    = pc;
        #1;
        check({tag, " taken"}, 32'(pred_taken), 32'(exp_tk));
        check({tag, " npc"}, npc_pred, exp_npc);
    endtask

    // One EX operation for one clock; ex_mispredict is checked before the edge.
    task automatic ex_op(input string tag, input logic br, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic tk, input logic pd,
                         input logic [3:0] gh, input logic exp_mis);
        ex_valid      = 1'b1;
        ex_is_br      = br;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_taken      = tk;
        ex_pred_taken = pd;
        ex_ghr        = gh;
        #1;
        check({tag, " mispredict"}, 32'(ex_mispredict), 32'(exp_mis));
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        ex_is_br = 1'b0;
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; pc_if = 32'h0;
        ex_valid = 1'b0; ex_is_br = 1'b0; ex_taken = 1'b0; ex_pc = 32'h0;
        ex_target = 32'h0; ex_pred_taken = 1'b0; ex_ghr = 4'h0;
        #12 rst = 1'b0;

        // Reset state
        lookup("rst_lookup", 32'h100, 1'b0, 32'h104);
        check("rst_ghr", 32'(pred_ghr), 32'h0);
        check("rst_cnt_correct", cnt_correct, 32'd0);
        check("rst_cnt_wrong", cnt_wrong, 32'd0);

        // Training and GHR recovery / speculative shift
        ex_op("br1", 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 4'h0, 1'b1);
        check("br1_cnt_wrong", cnt_wrong, 32'd1);
        check("br1_ghr", 32'(pred_ghr), 32'h1);
        ex_op("br2", 1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 4'h1, 1'b0);
        check("br2_cnt_correct", cnt_correct, 32'd1);
        check("br2_ghr_hold", 32'(pred_ghr), 32'h1);
        lookup("hit100", 32'h100, 1'b1, 32'h200);
        check("hit100_ghr", 32'(pred_ghr), 32'h1);
        if_valid = 1'b1;
        @(posedge clk); #1;
        if_valid = 1'b0;
        check("spec_shift_ghr", 32'(pred_ghr), 32'h3);

        // Mispredict recovery overrides a same-cycle speculative shift
        ex_op("br3", 1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 4'h3, 1'b0);
        lookup("hit100_g3", 32'h100, 1'b1, 32'h200);
        if_valid = 1'b1;
        ex_op("br_recover", 1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 4'h5, 1'b1);
        if_valid = 1'b0;
        check("recover_ghr", 32'(pred_ghr), 32'ha);
        check("recover_cnt_wrong", cnt_wrong, 32'd2);
        check("recover_cnt_correct", cnt_correct, 32'd2);

        // Fresh state for replacement tests
        rst = 1'b1; #3; rst = 1'b0; #1;
        check("rst2_cnt_wrong", cnt_wrong, 32'd0);

        // LRU replacement in set 0
        ex_op("a100", 1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 4'h0, 1'b0);
        ex_op("a110", 1'b1, 32'h110, 32'h300, 1'b1, 1'b1, 4'h0, 1'b0);
        ex_op("a100b", 1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 4'h0, 1'b0);
        ex_op("a120", 1'b1, 32'h120, 32'h400, 1'b1, 1'b1, 4'h0, 1'b0);
        lookup("lru100", 32'h100, 1'b1, 32'h200);
        lookup("lru120", 32'h120, 1'b1, 32'h400);
        lookup("lru110_evicted", 32'h110, 1'b0, 32'h114);
        check("lru_cnt_correct", cnt_correct, 32'd4);

        // Not-taken misses do not allocate; the PHT counter saturates at 0
        ex_op("nt140a", 1'b1, 32'h140, 32'h500, 1'b0, 1'b0, 4'h0, 1'b0);
        ex_op("nt140b", 1'b1, 32'h140, 32'h500, 1'b0, 1'b0, 4'h0, 1'b0);
        lookup("nt140_miss", 32'h140, 1'b0, 32'h144);
        lookup("nt_kept100", 32'h100, 1'b1, 32'h200);
        ex_op("t140a", 1'b1, 32'h140, 32'h500, 1'b1, 1'b1, 4'h0, 1'b0);
        lookup("sat140_weak", 32'h140, 1'b0, 32'h144);
        lookup("evict100", 32'h100, 1'b0, 32'h104);
        ex_op("t140b", 1'b1, 32'h140, 32'h500, 1'b1, 1'b1, 4'h0, 1'b0);
        lookup("t140_hit", 32'h140, 1'b1, 32'h500);
        check("nt_cnt_correct", cnt_correct, 32'd8);
        check("nt_cnt_wrong", cnt_wrong, 32'd0);

        // Non-branch hit invalidates the stale entry without counting
        ex_op("stale120", 1'b0, 32'h120, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        lookup("stale120_miss", 32'h120, 1'b0, 32'h124);
        lookup("stale_kept140", 32'h140, 1'b1, 32'h500);
        check("stale_cnt_correct", cnt_correct, 32'd8);

        // Asynchronous reset between edges with live entries
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_taken", 32'(pred_taken), 32'h0);
        check("arst_npc", npc_pred, 32'h144);
        check("arst_ghr", 32'(pred_ghr), 32'h0);
        check("arst_cnt_correct", cnt_correct, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lookup("post_rst140", 32'h140, 1'b0, 32'h144);
        ex_op("post_rst_br", 1'b1, 32'h180, 32'h600, 1'b1, 1'b1, 4'h0, 1'b0);
        check("post_rst_cnt", cnt_correct, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gshare_btb.md
GSHARE_BTB -- requirements
Module: gshare_btb

Interface
REQ-001 The block SHALL have parameter SETS_LOG2, default 2, giving log2 of the number of BTB sets (allowed range 1-8).
REQ-002 The block SHALL have parameter WAYS, default 2, giving the BTB associativity (power of two, 1-8).
REQ-003 The block SHALL have parameter GHR_LEN, default 4, giving the global history width (2..PHT_LOG2).
REQ-004 The block SHALL have parameter PHT_LOG2, default 6, giving log2 of the number of PHT 2-bit counters.
REQ-005 The block SHALL have parameter CNT_W, default 32, giving the statistics counter width.
REQ-006 clk  in  1  clock; all state updates on posedge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 if_valid  in  1  fetch slot valid; enables the speculative GHR shift.
REQ-009 pc_if  in  32  fetch PC.
REQ-010 npc_pred  out  32  predicted next PC.
REQ-011 pred_taken  out  1  prediction is taken.
REQ-012 pred_ghr  out  GHR_LEN  GHR used for this prediction; the pipeline carries it to EX.
REQ-013 ex_valid, ex_is_br, ex_taken  in  1 each  EX slot valid, EX instruction is a conditional branch, actual outcome.
REQ-014 ex_pc, ex_target  in  32 each  EX PC, resolved branch target.
REQ-015 ex_pred_taken  in  1 and ex_ghr  in  GHR_LEN  prediction and history carried from IF.
REQ-016 ex_mispredict  out  1  equals ex_valid & ex_is_br & (ex_taken != ex_pred_taken), combinational.
REQ-017 cnt_correct, cnt_wrong  out  CNT_W each  prediction statistics.

Function
REQ-018 Addressing SHALL be: set = pc[SETS_LOG2+1:2]; tag = pc[31:SETS_LOG2+2]; PHT index = pc[PHT_LOG2+1:2] XOR zero-extended GHR.
REQ-019 A BTB entry SHALL hold valid, tag, target and a per-way LRU age of log2(WAYS) bits; at most one way per set matches a tag.
REQ-020 The lookup SHALL be combinational: hit = some valid way in the set with a matching tag; pred_taken = hit & PHT[idx][1]; npc_pred = pred_taken ? target : pc_if+4 (mod 2^32).
REQ-021 pred_ghr SHALL equal the current GHR register, which is the pre-shift value.
REQ-022 Speculative GHR update: if if_valid & hit, then GHR <= {GHR[GHR_LEN-2:0], pred_taken}; otherwise GHR holds.
REQ-023 On ex_mispredict, GHR SHALL be loaded with {ex_ghr[GHR_LEN-2:0], ex_taken}; this overrides a same-cycle speculative shift.
REQ-024 On ex_valid & ex_is_br, PHT[ex_pc[PHT_LOG2+1:2] ^ ex_ghr] SHALL update as a 2-bit saturating counter: +1 if taken, -1 if not (sat 0/3).
REQ-025 On an EX branch that hits in ex_pc's set, the hit way's target SHALL be set to ex_target and the way made MRU.
REQ-026 On an EX branch that misses and is taken, the block SHALL allocate the lowest-index invalid way, or else the way with max age; it SHALL write valid, tag and target and make that way MRU.
REQ-027 An EX branch that misses and is not taken SHALL NOT allocate and SHALL NOT change LRU.
REQ-028 When ex_valid & !ex_is_br hits a BTB entry (stale entry), that way SHALL be invalidated; its age SHALL be unchanged.
REQ-029 LRU update: the touched way's age becomes 0; every way in the set with age < the touched way's old age increments by 1; other ages hold.
REQ-030 When EX and IF access the same entry in the same cycle, IF SHALL see the pre-update value; there is no bypass.
REQ-031 On ex_valid & ex_is_br, cnt_correct increments if !ex_mispredict and cnt_wrong increments otherwise; both saturate at all-ones.

Reset
REQ-032 On rst (asynchronous, active-high) the block SHALL clear: all valid=0, targets/tags=0, way w age=w, all PHT=2'b01, GHR=0, cnt_correct=cnt_wrong=0.
REQ-033 While in reset the outputs SHALL be pred_taken=0, npc_pred=pc_if+4, pred_ghr=0; a reset mid-operation discards all in-flight updates.

Verification (default parameters)
REQ-034 After reset, pc_if=0x100 -> pred_taken=0, npc_pred=0x104, pred_ghr=0, counters 0.
REQ-035 EX br pc=0x100 taken tgt=0x200, ex_ghr=0, pred=0 -> ex_mispredict=1, cnt_wrong=1, GHR=0001. Repeat with ex_ghr=0001, pred=1 -> no mispredict, PHT[1]=2. Then pc_if=0x100 -> pred_taken=1, npc_pred=0x200, pred_ghr=0001; with if_valid=1, next GHR=0011.
REQ-036 Taken EX branches 0x100, 0x110, then 0x100 again, then 0x120 (all set 0) -> 0x110 is evicted; lookups of 0x100 and 0x120 hit, 0x110 misses.
REQ-037 Not-taken EX branch pc=0x140 on a miss -> no allocation, lookup of 0x140 misses; the PHT counter already at 0 stays 0.
REQ-038 Same cycle: if_valid hit with pred_taken=1 (GHR=0011) and ex_mispredict with ex_ghr=0101, ex_taken=0 -> GHR=1010.
REQ-039 Assert rst between clock edges with live entries -> outputs return to reset values immediately, and the first lookup after release misses.
